// File: rtl/unified_mem_arbiter_if.sv
// Core/memory bus of unified_mem_arbiter: IF and DM request channels plus the memory macro port.
// slave = arbiter side, master = core/memory side.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between fetch (IF) and load/store (DM).
// Optional ARB_STATS_EN adds saturating grant/conflict statistics outputs.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned MEM_LAT         = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]          stat_if_cnt,
  output logic [31:0]          stat_dm_cnt,
  output logic [31:0]          stat_conflict_cnt
`endif
);
  localparam int unsigned LAT_W  = $clog2(MEM_LAT + 1);
  localparam int unsigned STRK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state, state_nxt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STRK_W-1:0]   streak;
  logic                owner_dm;
  logic                owner_store;
  logic                grant_if;
  logic                grant_dm;
  logic                done;
  logic                streak_full;
  logic [ADDR_W-1:0]   if_word;
  logic [ADDR_W-1:0]   dm_word;

  assign if_word     = bus.if_addr[ADDR_W+1:2];
  assign dm_word     = bus.dm_addr[ADDR_W+1:2];
  assign streak_full = (streak == STRK_W'(MAX_DATA_STREAK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory strobes are driven straight from the grant decision so the access starts in the grant cycle.
  always_comb begin
    state_nxt     = state;
    grant_if      = 1'b0;
    grant_dm      = 1'b0;
    done          = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        if (bus.dm_req && !(bus.if_req && streak_full)) grant_dm = 1'b1;
        else if (bus.if_req)                            grant_if = 1'b1;
        if (grant_dm) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = bus.dm_we;
          bus.mem_be    = bus.dm_we ? bus.dm_be : 4'hF;
          bus.mem_addr  = dm_word;
          bus.mem_wdata = bus.dm_we ? bus.dm_wdata : '0;
          state_nxt     = WAIT;
        end else if (grant_if) begin
          bus.mem_en    = 1'b1;
          bus.mem_be    = 4'hF;
          bus.mem_addr  = if_word;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.if_gnt = grant_if;
  assign bus.dm_gnt = grant_dm;
  assign bus.busy   = (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt       <= '0;
      streak        <= '0;
      owner_dm      <= 1'b0;
      owner_store   <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.if_rvalid <= done && !owner_dm;
      bus.dm_rvalid <= done && owner_dm;
      if (grant_if || grant_dm) begin
        lat_cnt     <= LAT_W'(MEM_LAT);
        owner_dm    <= grant_dm;
        owner_store <= grant_dm && bus.dm_we;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (done) begin
        if (!owner_dm)         bus.if_rdata <= bus.mem_rdata;
        else if (!owner_store) bus.dm_rdata <= bus.mem_rdata;
      end
      // Streak only grows while a fetch is actually being held off.
      if (grant_if)      streak <= '0;
      else if (grant_dm) streak <= bus.if_req ? streak + 1'b1 : '0;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_cnt       <= '0;
      stat_dm_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (grant_if && stat_if_cnt != '1) stat_if_cnt <= stat_if_cnt + 1'b1;
      if (grant_dm && stat_dm_cnt != '1) stat_dm_cnt <= stat_dm_cnt + 1'b1;
      if (state == IDLE && bus.if_req && bus.dm_req && stat_conflict_cnt != '1)
        stat_conflict_cnt <= stat_conflict_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a cycle-count reference model and a behavioural memory.
module tb_unified_mem_arbiter;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned MEM_LAT = 3;
  localparam int unsigned MAXS    = 4;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef ARB_STATS_EN
  logic [31:0] stat_if_cnt, stat_dm_cnt, stat_conflict_cnt;
`endif

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef ARB_STATS_EN
    , .stat_if_cnt(stat_if_cnt), .stat_dm_cnt(stat_dm_cnt), .stat_conflict_cnt(stat_conflict_cnt)
`endif
  );

  // Behavioural memory macro: unwritten words read a fixed hash of their address.
  logic [31:0] mem     [DEPTH];
  logic        written [DEPTH];
  logic [31:0] rpipe   [MEM_LAT];
  assign bus.mem_rdata = rpipe[MEM_LAT-1];

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_read(input int unsigned a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    rpipe[0] <= 32'hBAD0_BAD0;
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]     <= merge(mem_read(int'(bus.mem_addr)), bus.mem_wdata, bus.mem_be);
        written[bus.mem_addr] <= 1'b1;
      end else begin
        rpipe[0] <= mem_read(int'(bus.mem_addr));
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one access occupies the memory for MEM_LAT+1 cycles from its grant.
  int          next_free = 0;
  int          rv_cycle  = -1;
  logic        rv_is_dm, rv_store;
  logic [31:0] rv_data;
  int          streak = 0;
  logic [31:0] exp_if_rdata = '0, exp_dm_rdata = '0;
  bit          ghist[$];
  int          gcyc[$];

  // Requesters: 0 random, 1 both always requesting, 2 back-to-back loads, 3 scripted only.
  int          mode = 3;
  logic        if_pend = 1'b0, dm_pend = 1'b0;
  logic [31:0] if_addr_q = '0, dm_addr_q = '0, dm_wdata_q = '0;
  logic        dm_we_q = 1'b0;
  logic [3:0]  dm_be_q = '0;

  task automatic model_reset();
    next_free = 0; rv_cycle = -1; streak = 0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    if_pend = 1'b0; dm_pend = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
  endtask

  task automatic drive_requests();
    if (!if_pend) begin
      if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) begin
        if_pend = 1'b1; if_addr_q = $urandom & 32'hF000_03FF;
      end
    end else if (mode == 0 && $urandom_range(0, 15) == 0) if_pend = 1'b0;
    if (!dm_pend) begin
      if (mode == 1 || mode == 2 || (mode == 0 && $urandom_range(0, 1) == 0)) begin
        dm_pend = 1'b1; dm_we_q = (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        dm_be_q = 4'($urandom); dm_addr_q = $urandom & 32'hF000_00FF; dm_wdata_q = $urandom;
      end
    end else if (mode == 0 && $urandom_range(0, 15) == 0) dm_pend = 1'b0;
    bus.if_req = if_pend;   bus.if_addr  = if_addr_q;
    bus.dm_req = dm_pend;   bus.dm_we    = dm_we_q;
    bus.dm_be  = dm_be_q;   bus.dm_addr  = dm_addr_q;   bus.dm_wdata = dm_wdata_q;
  endtask

  task automatic step();
    bit          idle, eg_dm, eg_if, rv_now;
    logic [31:0] a;
    logic [ADDR_W-1:0] w;
    @(posedge clk); #1;
    cyc++;
    drive_requests();
    #3;
    idle   = (cyc >= next_free);
    rv_now = (cyc == rv_cycle);
    eg_dm  = idle && bus.dm_req && !(bus.if_req && streak == MAXS);
    eg_if  = idle && bus.if_req && !eg_dm;
    a      = eg_dm ? bus.dm_addr : bus.if_addr;
    w      = a[ADDR_W+1:2];
    check_eq("dm_gnt", bus.dm_gnt, eg_dm);
    check_eq("if_gnt", bus.if_gnt, eg_if);
    check_eq("mem_en", bus.mem_en, eg_dm || eg_if);
    check_eq("mem_we", bus.mem_we, eg_dm && bus.dm_we);
    check_eq("mem_wdata", bus.mem_wdata, (eg_dm && bus.dm_we) ? bus.dm_wdata : 32'h0);
    check_eq("busy", bus.busy, !idle);
    if (eg_dm || eg_if) begin
      check_eq("mem_addr", 32'(bus.mem_addr), 32'(w));
      check_eq("mem_be", 32'(bus.mem_be), (eg_dm && bus.dm_we) ? 32'(bus.dm_be) : 32'hF);
    end
    check_eq("if_rvalid", bus.if_rvalid, rv_now && !rv_is_dm);
    check_eq("dm_rvalid", bus.dm_rvalid, rv_now && rv_is_dm);
    if (rv_now) begin
      if (!rv_is_dm)     exp_if_rdata = rv_data;
      else if (!rv_store) exp_dm_rdata = rv_data;
    end
    check_eq("if_rdata", bus.if_rdata, exp_if_rdata);
    check_eq("dm_rdata", bus.dm_rdata, exp_dm_rdata);
    if (eg_dm || eg_if) begin
      next_free = cyc + MEM_LAT + 1;
      rv_cycle  = next_free;
      rv_is_dm  = eg_dm;
      rv_store  = eg_dm && bus.dm_we;
      rv_data   = rv_store ? 32'h0 : mem_read(int'(w));
      ghist.push_back(eg_dm);
      gcyc.push_back(cyc);
      if (eg_if) begin streak = 0; if_pend = 1'b0; end
      else begin streak = bus.if_req ? streak + 1 : 0; dm_pend = 1'b0; end
    end
  endtask

  task automatic drain();
    mode = 3; if_pend = 1'b0; dm_pend = 1'b0;
    repeat (MEM_LAT + 2) step();
  endtask

  initial begin
    int busy_cnt;
    int k;
    for (int i = 0; i < int'(DEPTH); i++) begin end
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_if_rvalid", bus.if_rvalid, 1'b0);
    check_eq("rst_dm_rvalid", bus.dm_rvalid, 1'b0);
    check_eq("rst_if_rdata", bus.if_rdata, 32'h0);
    check_eq("rst_dm_rdata", bus.dm_rdata, 32'h0);
    check_eq("rst_mem_en", bus.mem_en, 1'b0);
    check_eq("rst_gnts", {bus.if_gnt, bus.dm_gnt}, 2'b00);
    #1 rst_n = 1'b1;

    // Single fetch at 0x10, then a partial store at 0x20 read back by a load.
    if_pend = 1'b1; if_addr_q = 32'h10;
    repeat (MEM_LAT + 2) step();
    dm_pend = 1'b1; dm_we_q = 1'b1; dm_be_q = 4'b0011; dm_addr_q = 32'h20; dm_wdata_q = 32'hA5A5_1234;
    repeat (MEM_LAT + 2) step();
    dm_pend = 1'b1; dm_we_q = 1'b0; dm_be_q = 4'h0; dm_addr_q = 32'h20;
    repeat (MEM_LAT + 2) step();
    check_eq("store_merge", exp_dm_rdata, merge(init_word(8), 32'hA5A5_1234, 4'b0011));

    mode = 0;
    repeat (3000) step();
    drain();

    // Reset in the middle of an outstanding load abandons it.
    dm_pend = 1'b1; dm_we_q = 1'b0; dm_addr_q = 32'h44;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", bus.busy, 1'b0);
    check_eq("rst_mid_dm_rvalid", bus.dm_rvalid, 1'b0);
    check_eq("rst_mid_dm_rdata", bus.dm_rdata, 32'h0);
    check_eq("rst_mid_if_rdata", bus.if_rdata, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (MEM_LAT + 3) step();

    // Both requesters saturated: four data grants, then a forced fetch.
    ghist.delete();
    mode = 1;
    k = 0;
    while (ghist.size() < 10 && k < 100) begin step(); k++; end
    if (ghist.size() < 10) check_eq("order_timeout", 32'(ghist.size()), 32'd10);
    else for (int i = 0; i < 10; i++) check_eq("grant_order", 32'(ghist[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
    drain();

    // Back-to-back loads: one grant every MEM_LAT+1 cycles, busy in between.
    gcyc.delete();
    mode = 2;
    busy_cnt = 0;
    k = 0;
    while (gcyc.size() < 4 && k < 100) begin
      step(); k++;
      if (gcyc.size() >= 1 && !(gcyc.size() == 4 && gcyc[3] == cyc)) busy_cnt += int'(bus.busy);
    end
    if (gcyc.size() < 4) check_eq("b2b_timeout", 32'(gcyc.size()), 32'd4);
    else begin
      for (int i = 1; i < 4; i++) check_eq("b2b_gap", 32'(gcyc[i] - gcyc[i-1]), 32'(MEM_LAT + 1));
      check_eq("b2b_busy", 32'(busy_cnt), 32'(3 * MEM_LAT));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
